// File: rtl/spinner_round_ctrl.sv
// spinner_round_ctrl
//   Round sequencer for the LED spinner wheel. It owns the wheel position
//   counter and drives the speed code to the tick prescaler. A player stop
//   runs SPIN -> BRAKE (stepwise deceleration) -> EVAL -> HOLD. The stop
//   position is scored against the guess and drives the hit flag (dp).
//   Build option: define SPINNER_MISS_CLR_EN so that a missed round clears
//   the score. Without it, a miss leaves the score unchanged.

module spinner_round_ctrl #(
  parameter int NPOS        = 6,
  parameter int BRAKE_TICKS = 4,
  parameter int MIN_SPEED   = 0,
  parameter int SCORE_W     = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               tick,
  input  logic               stop_req,
  input  logic [3:0]         speed_req,
  input  logic [NPOS-1:0]    guess,
  output logic [2:0]         pos,
  output logic [3:0]         speed_sel,
  output logic               hit,
  output logic [SCORE_W-1:0] score,
  output logic               busy,
  output logic               round_done
);

  localparam int                 BCW        = (BRAKE_TICKS > 1) ? $clog2(BRAKE_TICKS) : 1;
  localparam logic [2:0]         POS_LAST   = 3'(NPOS - 1);
  localparam logic [2:0]         POS_ONE    = 3'd1;
  localparam logic [BCW-1:0]     BRAKE_LAST = BCW'(BRAKE_TICKS - 1);
  localparam logic [BCW-1:0]     BRAKE_ONE  = BCW'(1);
  localparam logic [3:0]         SPEED_MIN  = 4'(MIN_SPEED);
  localparam logic [3:0]         SPEED_ONE  = 4'd1;
  localparam logic [SCORE_W-1:0] SCORE_ONE  = SCORE_W'(1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SPIN,
    ST_BRAKE,
    ST_EVAL,
    ST_HOLD
  } state_t;

  state_t             state;
  state_t             state_nxt;

  logic               stop_meta;
  logic               stop_s;
  logic               stop_s_d;
  logic               stop_rise;

  logic [BCW-1:0]     brake_cnt;
  logic               brake_last;
  logic               speed_at_min;

  logic [7:0]         guess_ext;
  logic               guess_at_pos;
  logic [2:0]         pos_next;
  logic [SCORE_W-1:0] score_inc;

  // control strobes decoded from the current state
  logic               pos_step;
  logic               brake_step;
  logic               spin_track;
  logic               eval_now;
  logic               hold_next;

  assign stop_rise    = stop_s & ~stop_s_d;
  assign brake_last   = (brake_cnt == BRAKE_LAST);
  assign speed_at_min = (speed_sel <= SPEED_MIN);
  assign guess_ext    = 8'(guess);
  assign guess_at_pos = guess_ext[pos];
  assign pos_next     = (pos == POS_LAST) ? '0 : pos + POS_ONE;
  assign score_inc    = (score == '1) ? score : score + SCORE_ONE;

  // Stop synchronizer and edge history. These flops reset to the "stopped"
  // level, so a stop held through reset is never taken as a fresh rise.
  // The level must be seen low before the wheel starts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stop_meta <= 1'b1;
      stop_s    <= 1'b1;
      stop_s_d  <= 1'b1;
    end else begin
      stop_meta <= stop_req;
      stop_s    <= stop_meta;
      stop_s_d  <= stop_s;
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:  if (!stop_s) state_nxt = ST_SPIN;
      ST_SPIN:  if (stop_rise) state_nxt = ST_BRAKE;
      ST_BRAKE: if (tick && brake_last && speed_at_min) state_nxt = ST_EVAL;
      ST_EVAL:  state_nxt = ST_HOLD;
      ST_HOLD:  if (!stop_s) state_nxt = ST_SPIN;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // FSM output decode: busy flag and per-state datapath strobes
  always_comb begin
    busy       = 1'b0;
    pos_step   = 1'b0;
    brake_step = 1'b0;
    spin_track = 1'b0;
    eval_now   = 1'b0;
    hold_next  = (state_nxt == ST_HOLD);
    unique case (state)
      ST_SPIN: begin
        busy       = 1'b1;
        pos_step   = tick;
        spin_track = 1'b1;
      end
      ST_BRAKE: begin
        busy       = 1'b1;
        pos_step   = tick;
        brake_step = tick;
      end
      ST_EVAL: eval_now = 1'b1;
      default: ;
    endcase
  end

  // Wheel position: advances on every tick while spinning or braking
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos <= '0;
    end else if (pos_step) begin
      pos <= pos_next;
    end
  end

  // Speed code follows the request in SPIN. It is frozen on the stop rise
  // and stepped down once per brake period.
  // A SPIN cycle always loads speed_req. The cycle that detects the rise
  // therefore latches the current request as the braking start speed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      speed_sel <= '0;
    end else if (spin_track) begin
      speed_sel <= speed_req;
    end else if (brake_step && brake_last && !speed_at_min) begin
      speed_sel <= speed_sel - SPEED_ONE;
    end
  end

  // Brake tick counter: held at zero in SPIN and counts ticks per speed step
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      brake_cnt <= '0;
    end else if (spin_track) begin
      brake_cnt <= '0;
    end else if (brake_step) begin
      brake_cnt <= brake_last ? '0 : brake_cnt + BRAKE_ONE;
    end
  end

  // Score update: evaluated once per round in EVAL, saturating on hits
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      score <= '0;
    end else if (eval_now) begin
      if (guess_at_pos) begin
        score <= score_inc;
      end else begin
`ifdef SPINNER_MISS_CLR_EN
        score <= '0;
`else
        score <= score;
`endif
      end
    end
  end

  // Hit flag: it tracks guess[pos] whenever the next state is HOLD. That
  // makes hit, score and round_done all appear in the first HOLD cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit <= 1'b0;
    end else begin
      hit <= hold_next & guess_at_pos;
    end
  end

  // Round completion pulse, one cycle after EVAL
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      round_done <= 1'b0;
    end else begin
      round_done <= eval_now;
    end
  end

endmodule

// File: tb/tb_spinner_round_ctrl.sv
// Self-checking bench for spinner_round_ctrl: hand-computed round table,
// directed corner sequences and randomized rounds against a tick-level model.
`timescale 1ns/1ps
module tb_spinner_round_ctrl;

  localparam int NPOS = 6;
  localparam int BT   = 4;
  localparam int MINS = 0;
  localparam int SW   = 4;
  localparam int SMAX = (1 << SW) - 1;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            tick = 1'b0;
  logic            stop_req = 1'b0;
  logic [3:0]      speed_req = '0;
  logic [NPOS-1:0] guess = '0;
  logic [2:0]      pos;
  logic [3:0]      speed_sel;
  logic            hit;
  logic [SW-1:0]   score;
  logic            busy;
  logic            round_done;

  int tests = 0;
  int fails = 0;
  int rd_count = 0;
  int mpos = 0;
  int mscore = 0;

  typedef struct {
    int              spd;
    int              spin;
    logic [NPOS-1:0] g;
    int              exp_brake;
    int              exp_pos;
    int              exp_hit;
  } vec_t;

  vec_t tbl [5];

  spinner_round_ctrl #(
    .NPOS(NPOS),
    .BRAKE_TICKS(BT),
    .MIN_SPEED(MINS),
    .SCORE_W(SW)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .tick(tick),
    .stop_req(stop_req),
    .speed_req(speed_req),
    .guess(guess),
    .pos(pos),
    .speed_sel(speed_sel),
    .hit(hit),
    .score(score),
    .busy(busy),
    .round_done(round_done)
  );

  always #5 clk = ~clk;

  // counts the cycles in which round_done is high, so pulse width is also checked
  always @(negedge clk) if (rst_n && round_done) rd_count++;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1);
  end

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int brake_len(input int spd);
    int top;
    top = (spd > MINS) ? spd : MINS;
    return (top - MINS + 1) * BT;
  endfunction

  function automatic int exp_speed(input int spd, input int n);
    if (spd <= MINS) return spd;
    return spd - n / BT;
  endfunction

  task automatic score_update(input bit h);
    if (h) mscore = (mscore < SMAX) ? mscore + 1 : SMAX;
`ifdef SPINNER_MISS_CLR_EN
    else mscore = 0;
`endif
  endtask

  task automatic do_tick();
    @(negedge clk); tick = 1'b1;
    @(negedge clk); tick = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_pos"}, int'(pos), 0);
    check({tag, "_speed"}, int'(speed_sel), 0);
    check({tag, "_hit"}, int'(hit), 0);
    check({tag, "_score"}, int'(score), 0);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_round_done"}, int'(round_done), 0);
  endtask

  task automatic start_spin();
    stop_req = 1'b0;
    repeat (4) @(negedge clk);
    check("restart_busy", int'(busy), 1);
    check("restart_hit", int'(hit), 0);
  endtask

  // one full round from SPIN: spin ticks, stop, brake until idle, score check
  task automatic run_round(input int spd, input int spin, input logic [NPOS-1:0] g,
                           input bit scramble, input bit toggle, output int brake_n);
    int rd0;
    int r;
    bit h;
    @(negedge clk); guess = g; speed_req = 4'(spd);
    @(negedge clk);
    check("spin_speed_follow", int'(speed_sel), spd);
    check("spin_busy", int'(busy), 1);
    for (int i = 0; i < spin; i++) begin
      if (scramble) begin
        r = int'($urandom_range(0, 15));
        speed_req = 4'(r);
        @(negedge clk);
        check("spin_speed_rand", int'(speed_sel), r);
      end
      do_tick();
      mpos = (mpos + 1) % NPOS;
      check("spin_pos", int'(pos), mpos);
    end
    speed_req = 4'(spd);
    @(negedge clk);
    check("spin_speed_final", int'(speed_sel), spd);
    rd0 = rd_count;
    stop_req = 1'b1;
    repeat (4) @(negedge clk);
    brake_n = 0;
    while (busy && brake_n < 200) begin
      check("brake_speed", int'(speed_sel), exp_speed(spd, brake_n));
      if (scramble) speed_req = 4'($urandom_range(0, 15));
      do_tick();
      brake_n++;
      mpos = (mpos + 1) % NPOS;
      if (toggle && brake_n == 2) begin
        stop_req = 1'b0;
        repeat (4) @(negedge clk);
        stop_req = 1'b1;
        repeat (4) @(negedge clk);
      end
    end
    check("brake_len", brake_n, brake_len(spd));
    check("round_done_cycles", rd_count - rd0, 1);
    h = g[mpos];
    score_update(h);
    check("hold_pos", int'(pos), mpos);
    check("hold_hit", int'(hit), int'(h));
    check("hold_score", int'(score), mscore);
    check("hold_busy", int'(busy), 0);
  endtask

  initial begin
    int n;
    int rd0;

    // hand-computed rounds starting from pos 0 after reset
    tbl[0] = '{spd: 2, spin: 7, g: 6'b000010, exp_brake: 12, exp_pos: 1, exp_hit: 1};
    tbl[1] = '{spd: 0, spin: 3, g: 6'b100000, exp_brake: 4,  exp_pos: 2, exp_hit: 0};
    tbl[2] = '{spd: 1, spin: 2, g: 6'b000001, exp_brake: 8,  exp_pos: 0, exp_hit: 1};
    tbl[3] = '{spd: 5, spin: 1, g: 6'b111111, exp_brake: 24, exp_pos: 1, exp_hit: 1};
    tbl[4] = '{spd: 3, spin: 0, g: 6'b010100, exp_brake: 16, exp_pos: 5, exp_hit: 0};

    // reset and start-up
    repeat (3) @(negedge clk);
    check_reset("reset");
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_after_reset_busy", int'(busy), 0);
    repeat (4) @(negedge clk);
    check("spin_after_reset_busy", int'(busy), 1);

    // table-driven rounds
    for (int i = 0; i < 5; i++) begin
      if (i > 0) start_spin();
      run_round(tbl[i].spd, tbl[i].spin, tbl[i].g, 1'b0, 1'b0, n);
      check("tbl_brake", n, tbl[i].exp_brake);
      check("tbl_pos", int'(pos), tbl[i].exp_pos);
      check("tbl_hit", int'(hit), tbl[i].exp_hit);
    end

    // HOLD: guess changes update hit one clock later, score and pos frozen
    rd0 = rd_count;
    @(negedge clk); guess = 6'b100000;
    @(negedge clk);
    check("hold_guess_on_hit", int'(hit), 1);
    check("hold_guess_on_score", int'(score), mscore);
    guess = '0;
    @(negedge clk);
    check("hold_guess_off_hit", int'(hit), 0);
    repeat (3) do_tick();
    check("hold_tick_pos", int'(pos), mpos);
    check("hold_score_stable", int'(score), mscore);
    check("hold_no_round_done", rd_count - rd0, 0);

    // stop released and re-asserted during BRAKE
    start_spin();
    run_round(2, 1, 6'b111111, 1'b0, 1'b1, n);
    check("toggle_brake_len", n, 12);

    // randomized rounds against the model
    for (int i = 0; i < 20; i++) begin
      start_spin();
      run_round(int'($urandom_range(0, 5)), int'($urandom_range(0, 6)),
                NPOS'($urandom_range(0, 63)), 1'b1, 1'($urandom_range(0, 1)), n);
    end

    // score saturation, then a miss
    for (int i = 0; i < 16; i++) begin
      start_spin();
      run_round(0, 0, 6'b111111, 1'b0, 1'b0, n);
    end
    check("saturate_score", int'(score), 15);
    start_spin();
    run_round(0, 0, 6'b000000, 1'b0, 1'b0, n);
`ifdef SPINNER_MISS_CLR_EN
    check("miss_after_sat", int'(score), 0);
`else
    check("miss_after_sat", int'(score), 15);
`endif

    // reset in the middle of BRAKE, released with stop held
    start_spin();
    run_round(0, 0, 6'b111111, 1'b0, 1'b0, n);
    start_spin();
    @(negedge clk); speed_req = 4'd3;
    repeat (2) @(negedge clk);
    stop_req = 1'b1;
    repeat (4) @(negedge clk);
    do_tick();
    do_tick();
    check("pre_reset_busy", int'(busy), 1);
    rst_n = 1'b0;
    #1;
    check_reset("mid_brake_reset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    mpos = 0;
    mscore = 0;
    repeat (8) @(negedge clk);
    check("stop_held_idle_busy", int'(busy), 0);
    do_tick();
    check("stop_held_idle_pos", int'(pos), 0);
    stop_req = 1'b0;
    repeat (4) @(negedge clk);
    check("release_spin_busy", int'(busy), 1);
    do_tick();
    check("release_spin_pos", int'(pos), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
